bus1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 5-source Bus_1 multiplexer of the RISC-SPM datapath. Arbitrates among five bus sources (R0_out, R1_out, R2_out, R3_out, Sel_Bus_1_Mux), drives the mux select, and indicates when Bus_1 carries a granted value. Owners are bounded by a hold limit, so no source can starve the others. Sits between the control unit's bus-transfer requests and the Bus_1 multiplexer select input.

---
 rtl/bus1_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus1_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus1_arbiter.sv
// ---------------------------------------------------------------------------
// bus1_arbiter
//
// Round-robin arbiter and sequencer for the five-source Bus_1 multiplexer of
// the RISC-SPM datapath. Picks one of R0_out, R1_out, R2_out, R3_out and
// Sel_Bus_1_Mux, drives the mux select and flags when Bus_1 carries a granted
// value. An owner keeps the bus for at most MAX_HOLD consecutive cycles while
// anyone else is waiting, so no source starves.
//
// Handshake: req[i] is a level request from channel i. The channel owns Bus_1
// in every cycle where gnt[i] is high, and it keeps ownership for as long as
// it holds req[i] high, up to the hold limit under contention. Dropping req[i]
// at edge n releases the bus at edge n. There is no separate acknowledge.
//
// Parameters:
//   MAX_HOLD  max consecutive granted cycles while others wait (1..15)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req[4:0]   request vector; 0..3 = R0..R3, 4 = Sel_Bus_1_Mux
//   gnt[4:0]   registered one-hot grant, or zero when idle
//   sel[2:0]   registered mux select (current or most recent owner)
//   bus_valid  high exactly when gnt is non-zero
//   switch_p   one-cycle pulse in the first cycle of every new grant
// ---------------------------------------------------------------------------
module bus1_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  output logic [4:0] gnt,
  output logic [2:0] sel,
  output logic       bus_valid,
  output logic       switch_p
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [4:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             switch_q, switch_d;

  // Scan channels last+1, last+2, ... last (mod 5) and return the first one
  // requesting. The pointer channel itself is checked last, which is what
  // lets a preempted owner lose to any other requester.
  function automatic logic [2:0] pick_winner(input logic [4:0] r,
                                             input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    pick_winner = last;
    idx         = last;
    found       = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (!found && r[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  logic [2:0] winner;
  logic [4:0] owner_oh;
  logic       others_req;

  assign winner     = pick_winner(req, last_q);
  assign owner_oh   = 5'b00001 << owner_q;
  assign others_req = |(req & ~owner_oh);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    hold_d   = hold_q;
    switch_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_GRANT;
          owner_d  = winner;
          last_d   = winner;
          hold_d   = HOLD_ONE;
          switch_d = 1'b1;
        end
      end
      ST_GRANT: begin
        if (req[owner_q] && !(hold_q == HOLD_MAX && others_req)) begin
          // Continue: the counter saturates so a lone requester keeps the bus.
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_ONE;
        end else if (|req) begin
          // Release with others waiting, or preemption: hand over directly,
          // no idle bubble. winner != owner here in both cases.
          owner_d  = winner;
          last_d   = winner;
          hold_d   = HOLD_ONE;
          switch_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_d = (state_d == ST_GRANT) ? (5'b00001 << owner_d) : 5'b00000;
    sel_d = (state_d == ST_GRANT) ? owner_d : sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 3'd0;
      last_q   <= 3'd4;
      hold_q   <= '0;
      gnt_q    <= 5'b00000;
      sel_q    <= 3'd0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      switch_q <= switch_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = |gnt_q;
  assign switch_p  = switch_q;

endmodule

// File: tb/tb_bus1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus1_arbiter
//
// Two arbiters (MAX_HOLD=4 and MAX_HOLD=1) see the same rst/req stream. For
// every driven cycle a reference model predicts {gnt, sel, bus_valid,
// switch_p} for each instance and pushes it into that instance's expected
// queue; a monitor pops and compares one entry per cycle, shortly after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_bus1_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = 5'b00000;

  logic [4:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       bv_a, bv_b, sw_a, sw_b;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bus1_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .sel(sel_a), .bus_valid(bv_a), .switch_p(sw_a)
  );

  bus1_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .sel(sel_b), .bus_valid(bv_b), .switch_p(sw_b)
  );

  // ---------------- reference model ----------------
  // Per instance: whether the bus is owned, who owns it, the round-robin
  // pointer, how many cycles the owner has held, and the displayed select.
  bit m_busy [2];
  int m_owner[2];
  int m_last [2];
  int m_hold [2];
  int m_sel  [2];

  function automatic int max_hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_step(input int k, input logic r, input logic [4:0] rq,
                            output logic [9:0] e);
    bit sw;
    bit keep;
    int others;
    int w;
    sw = 1'b0;
    if (r) begin
      m_busy[k] = 1'b0; m_owner[k] = 0; m_last[k] = 4;
      m_hold[k] = 0;    m_sel[k]   = 0;
    end else begin
      others = 0;
      for (int c = 0; c < 5; c++)
        if (rq[c] && !(m_busy[k] && c == m_owner[k])) others++;
      keep = m_busy[k] && rq[m_owner[k]] &&
             !(m_hold[k] == max_hold_of(k) && others > 0);
      if (keep) begin
        if (m_hold[k] < max_hold_of(k)) m_hold[k]++;
      end else if (rq != 5'b00000) begin
        w = -1;
        for (int s = 1; s <= 5; s++)
          if (w < 0 && rq[(m_last[k] + s) % 5]) w = (m_last[k] + s) % 5;
        m_busy[k] = 1'b1; m_owner[k] = w; m_last[k] = w;
        m_hold[k] = 1;    m_sel[k]   = w;
        sw = 1'b1;
      end else begin
        m_busy[k] = 1'b0;
      end
    end
    e[9:5] = m_busy[k] ? (5'b00001 << m_owner[k]) : 5'b00000;
    e[4:2] = 3'(m_sel[k]);
    e[1]   = m_busy[k];
    e[0]   = sw;
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic r, input logic [4:0] rq);
    logic [9:0] ea, eb;
    @(negedge clk);
    rst = r;
    req = rq;
    model_step(0, r, rq, ea);
    model_step(1, r, rq, eb);
    exp_q_a.push_back(ea);
    exp_q_b.push_back(eb);
  endtask

  task automatic apply_n(input logic r, input logic [4:0] rq, input int n);
    for (int i = 0; i < n; i++) apply(r, rq);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic compare(input string name, input logic [9:0] act,
                         input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t gnt/sel/valid/switch actual=%b/%0d/%b/%b required=%b/%0d/%b/%b",
               name, $time, act[9:5], act[4:2], act[1], act[0],
               exp[9:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() > 0) compare("inst_hold4", {gnt_a, sel_a, bv_a, sw_a}, exp_q_a.pop_front());
      if (exp_q_b.size() > 0) compare("inst_hold1", {gnt_b, sel_b, bv_b, sw_b}, exp_q_b.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    logic [4:0] rq;

    // Reset then single requester holding the bus for 20+ cycles
    apply_n(1'b1, 5'b00000, 2);
    apply_n(1'b0, 5'b00100, 21);

    // All five requesting: round-robin 0,1,2,3,4,0...
    apply_n(1'b1, 5'b00000, 1);
    apply_n(1'b0, 5'b11111, 45);

    // Release without bubble: ch1 owns, ch0 waiting, ch1 drops
    apply_n(1'b1, 5'b00000, 1);
    apply_n(1'b0, 5'b00010, 1);
    apply_n(1'b0, 5'b00011, 2);
    apply_n(1'b0, 5'b00001, 3);

    // Wrap and idle: ch4 owns, drops to idle, then 10001 grants ch0 first
    apply_n(1'b1, 5'b00000, 1);
    apply_n(1'b0, 5'b10000, 3);
    apply_n(1'b0, 5'b00000, 2);
    apply_n(1'b0, 5'b10001, 6);

    // Reset mid-grant of ch3 at hold 2, request kept high
    apply_n(1'b1, 5'b00000, 1);
    apply_n(1'b0, 5'b01000, 2);
    apply_n(1'b1, 5'b01000, 1);
    apply_n(1'b0, 5'b01000, 3);

    // Two contenders: alternates every cycle on the MAX_HOLD=1 instance
    apply_n(1'b1, 5'b00000, 1);
    apply_n(1'b0, 5'b01010, 10);

    // Randomized traffic with bursts and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        rq = 5'($urandom_range(0, 31));
      else
        rq = req ^ (5'b00001 << $urandom_range(0, 4)) ^
             (($urandom_range(0, 1) == 1) ? (5'b00001 << $urandom_range(0, 4)) : 5'b00000);
      apply(($urandom_range(0, 59) == 0), rq);
    end

    // Drain the scoreboard with a bounded wait
    budget = 0;
    while ((exp_q_a.size() > 0 || exp_q_b.size() > 0) && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q_a.size() > 0 || exp_q_b.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending actual=%0d/%0d required=0/0", exp_q_a.size(), exp_q_b.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
